// File: rtl/pe_data_loader.sv
// Operand loader: captures a DEPTH-word multi-lane block, passes each beat through,
// then replays the block for N passes. Optional reverse replay under PE_LOADER_REVERSE_EN.
module pe_data_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 1,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PASS_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din_v,
  input  logic [LANES*DATA_WIDTH*2-1:0]   din,
  output logic                            din_rdy,
  input  logic                            flush,
  input  logic                            replay_go,
  input  logic [PASS_WIDTH-1:0]           replay_passes,
  input  logic                            replay_rev,
  output logic                            dout_v,
  output logic [LANES*DATA_WIDTH*2-1:0]   dout,
  output logic                            dout_last,
  output logic                            busy,
  output logic [$clog2(DEPTH+1)-1:0]      fill_lvl
);

  localparam int unsigned WW = LANES * DATA_WIDTH * 2;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_REPLAY
  } state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [AW-1:0]         rd_addr, start_addr, next_addr, end_addr;
  logic [PASS_WIDTH-1:0] pass_q, pass_d, cur_passes, go_passes;
  logic [LW-1:0]         fill_d;
  logic [WW-1:0]         dout_d;
  logic                  dout_v_d, dout_last_d;
  logic                  accept, go, emit, pass_end, final_word;

  // Flush outranks both a beat and a replay request.
  assign accept     = din_v & din_rdy & ~flush;
  assign go         = (state_q == S_FULL) & replay_go & ~flush;
  assign emit       = go | (state_q == S_REPLAY);
  assign go_passes  = (replay_passes == '0) ? PASS_WIDTH'(1) : replay_passes;
  // The replay_go cycle already emits the first word, so read from the start address.
  assign rd_addr    = go ? start_addr : raddr_q;
  assign cur_passes = go ? go_passes : pass_q;
  assign pass_end   = (rd_addr == end_addr);
  assign final_word = pass_end & (cur_passes == PASS_WIDTH'(1));

`ifdef PE_LOADER_REVERSE_EN
  logic rev_q, cur_rev;

  assign cur_rev    = go ? replay_rev : rev_q;
  assign start_addr = replay_rev ? AW'(DEPTH - 1) : '0;
  assign end_addr   = cur_rev ? '0 : AW'(DEPTH - 1);
  assign next_addr  = cur_rev ? rd_addr - AW'(1) : rd_addr + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q <= 1'b0;
    end else if (go) begin
      rev_q <= replay_rev;
    end
  end
`else
  logic unused_replay_rev;

  assign unused_replay_rev = replay_rev;
  assign start_addr        = '0;
  assign end_addr          = AW'(DEPTH - 1);
  assign next_addr         = rd_addr + AW'(1);
`endif

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    fill_d      = fill_lvl;
    raddr_d     = raddr_q;
    pass_d      = pass_q;
    dout_d      = dout;
    dout_v_d    = 1'b0;
    dout_last_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      fill_d  = '0;
      raddr_d = '0;
      pass_d  = '0;
    end else if (accept) begin
      dout_d   = din;
      dout_v_d = 1'b1;
      wptr_d   = wptr_q + AW'(1);
      fill_d   = fill_lvl + LW'(1);
      state_d  = (fill_lvl == LW'(DEPTH - 1)) ? S_FULL : S_FILL;
    end else if (emit) begin
      dout_d      = mem[rd_addr];
      dout_v_d    = 1'b1;
      dout_last_d = final_word;
      raddr_d     = next_addr;
      pass_d      = pass_end ? cur_passes - PASS_WIDTH'(1) : cur_passes;
      state_d     = final_word ? S_FULL : S_REPLAY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      fill_lvl  <= '0;
      raddr_q   <= '0;
      pass_q    <= '0;
      dout      <= '0;
      dout_v    <= 1'b0;
      dout_last <= 1'b0;
      din_rdy   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      fill_lvl  <= fill_d;
      raddr_q   <= raddr_d;
      pass_q    <= pass_d;
      dout      <= dout_d;
      dout_v    <= dout_v_d;
      dout_last <= dout_last_d;
      din_rdy   <= (state_d == S_IDLE) || (state_d == S_FILL);
      busy      <= (state_d == S_REPLAY);
    end
  end

  // Block storage; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_pe_data_loader.sv
// Bench for pe_data_loader (LANES=4, DEPTH=32): directed table, hand-written corner
// sequences and random stimulus against a queue-based reference model.
module tb_pe_data_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned DP = 32;
  localparam int unsigned PW = 4;
  localparam int unsigned WW = LN * DW * 2;
  localparam int unsigned LW = $clog2(DP + 1);
`ifdef PE_LOADER_REVERSE_EN
  localparam bit REV_ON = 1'b1;
`else
  localparam bit REV_ON = 1'b0;
`endif

  logic          clk, rst;
  logic          din_v, din_rdy, flush, replay_go, replay_rev;
  logic [WW-1:0] din, dout;
  logic [PW-1:0] replay_passes;
  logic          dout_v, dout_last, busy;
  logic [LW-1:0] fill_lvl;

  int checks   = 0;
  int failures = 0;

  pe_data_loader #(
    .DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP), .PASS_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .din_v(din_v), .din(din), .din_rdy(din_rdy),
    .flush(flush), .replay_go(replay_go), .replay_passes(replay_passes),
    .replay_rev(replay_rev), .dout_v(dout_v), .dout(dout), .dout_last(dout_last),
    .busy(busy), .fill_lvl(fill_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane k of word n carries 100*k + n; n == 0 stands for the all-zero word.
  function automatic logic [WW-1:0] word(input int n);
    logic [WW-1:0] w;
    w = '0;
    if (n != 0) begin
      for (int k = 0; k < int'(LN); k++) w[k*64 +: 64] = 64'(100 * k + n);
    end
    return w;
  endfunction

  function automatic void chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: stored block plus a queue of words still owed by the current replay.
  logic [WW-1:0] blk[$];
  logic [WW-1:0] pend[$];
  logic [WW-1:0] m_dout;
  logic          m_v, m_last, m_rdy, m_busy;
  int            m_fill;

  function automatic void model_reset();
    blk.delete(); pend.delete();
    m_dout = '0; m_v = 0; m_last = 0; m_rdy = 0; m_busy = 0; m_fill = 0;
  endfunction

  function automatic void model_edge(input logic v, input logic [WW-1:0] d, input logic fl,
                                     input logic go, input logic [PW-1:0] np, input logic rv);
    int n;
    if (fl) begin
      blk.delete(); pend.delete();
      m_v = 0; m_last = 0;
    end else if (v && m_rdy) begin
      blk.push_back(d);
      m_dout = d; m_v = 1; m_last = 0;
    end else begin
      if (pend.size() == 0 && go && blk.size() == int'(DP)) begin
        n = (np == 0) ? 1 : int'(np);
        for (int p = 0; p < n; p++)
          for (int i = 0; i < int'(DP); i++)
            pend.push_back(blk[(REV_ON && rv) ? int'(DP) - 1 - i : i]);
      end
      if (pend.size() > 0) begin
        m_dout = pend.pop_front(); m_v = 1; m_last = (pend.size() == 0);
      end else begin
        m_v = 0; m_last = 0;
      end
    end
    m_rdy  = (blk.size() < int'(DP));
    m_busy = (pend.size() > 0);
    m_fill = blk.size();
  endfunction

  function automatic void check_model();
    checks++;
    if (dout_v !== m_v || dout_last !== m_last || din_rdy !== m_rdy || busy !== m_busy ||
        fill_lvl !== LW'(m_fill) || dout !== m_dout) begin
      failures++;
      $display("FAIL model @%0t: v=%0b last=%0b rdy=%0b busy=%0b fill=%0d dout=%h required v=%0b last=%0b rdy=%0b busy=%0b fill=%0d dout=%h",
               $time, dout_v, dout_last, din_rdy, busy, fill_lvl, dout,
               m_v, m_last, m_rdy, m_busy, m_fill, m_dout);
    end
  endfunction

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [WW-1:0] d, input logic fl, input logic go,
                      input logic [PW-1:0] np, input logic rv);
    din_v = v; din = d; flush = fl; replay_go = go; replay_passes = np; replay_rev = rv;
    @(posedge clk);
    model_edge(v, d, fl, go, np, rv);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fill_block(input int base);
    for (int n = 1; n <= int'(DP); n++) step(1'b1, word(base + n), 1'b0, 1'b0, '0, 1'b0);
  endtask

  // First word is already visible on entry; walks the rest of the replay.
  task automatic expect_seq(input string name, input int nwords, input int base, input bit down);
    int errs, pos, val;
    errs = 0;
    for (int i = 0; i < nwords; i++) begin
      pos = i % int'(DP);
      val = base + (down ? int'(DP) - pos : pos + 1);
      if (dout_v !== 1'b1 || dout !== word(val) || dout_last !== (i == nwords - 1)) errs++;
      if (i < nwords - 1) idle();
    end
    chk(name, WW'(errs), '0);
    chk({name, "_busy_end"}, WW'(busy), '0);
  endtask

  typedef struct {
    logic v; int n; logic fl; logic go; logic [PW-1:0] np;
    logic e_v; int e_n; logic e_rdy; int e_fill;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 7, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b1, 0}; // rdy still low out of reset
    tbl[1] = '{1'b1, 1, 1'b0, 1'b0, 4'd0, 1'b1, 1, 1'b1, 1};
    tbl[2] = '{1'b0, 0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1'b1, 1}; // dout holds
    tbl[3] = '{1'b1, 2, 1'b1, 1'b0, 4'd0, 1'b0, 1, 1'b1, 0}; // flush beats beat
    tbl[4] = '{1'b0, 0, 1'b0, 1'b1, 4'd2, 1'b0, 1, 1'b1, 0}; // go ignored in IDLE
    tbl[5] = '{1'b1, 5, 1'b0, 1'b0, 4'd0, 1'b1, 5, 1'b1, 1};
    tbl[6] = '{1'b1, 6, 1'b0, 1'b1, 4'd1, 1'b1, 6, 1'b1, 2}; // go ignored in FILL
    tbl[7] = '{1'b0, 0, 1'b1, 1'b0, 4'd0, 1'b0, 6, 1'b1, 0};

    rst = 1'b1; din_v = 0; din = '0; flush = 0; replay_go = 0; replay_passes = '0; replay_rev = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", WW'({dout_v, dout_last, din_rdy, busy, fill_lvl}), '0);
    chk("reset_dout", dout, '0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, word(tbl[i].n), tbl[i].fl, tbl[i].go, tbl[i].np, 1'b0);
      chk($sformatf("tbl%0d_v", i), WW'(dout_v), WW'(tbl[i].e_v));
      chk($sformatf("tbl%0d_dout", i), dout, word(tbl[i].e_n));
      chk($sformatf("tbl%0d_rdy", i), WW'(din_rdy), WW'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_fill", i), WW'(fill_lvl), WW'(tbl[i].e_fill));
    end

    // Fill 1..32, then a dropped 33rd beat
    fill_block(0);
    chk("fill_lvl_full", WW'(fill_lvl), WW'(DP));
    chk("fill_rdy_low", WW'(din_rdy), '0);
    step(1'b1, word(99), 1'b0, 1'b0, '0, 1'b0);
    chk("drop_v", WW'(dout_v), '0);
    chk("drop_dout", dout, word(32));

    // Two passes, then back-to-back single pass (passes = 0)
    step(1'b0, '0, 1'b0, 1'b1, 4'd2, 1'b0);
    expect_seq("replay2", 64, 0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    expect_seq("replay_b2b", 32, 0, 1'b0);
    idle();
    chk("after_replay_v", WW'(dout_v), '0);

    // Reverse request
    step(1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b1);
    expect_seq("replay_rev", 32, 0, REV_ON);
    idle();

    // Flush during 10th replay cycle
    step(1'b0, '0, 1'b0, 1'b1, 4'd3, 1'b0);
    repeat (8) idle();
    chk("pre_flush_dout", dout, word(9));
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("flush_outputs", WW'({dout_v, dout_last, din_rdy, fill_lvl}), WW'({1'b0, 1'b0, 1'b1, LW'(0)}));
    fill_block(50);
    step(1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    expect_seq("replay_after_flush", 32, 50, 1'b0);

    // Async reset after 5 accepted beats
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int n = 1; n <= 5; n++) step(1'b1, word(300 + n), 1'b0, 1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", WW'({dout_v, dout_last, din_rdy, busy, fill_lvl}), '0);
    chk("async_rst_dout", dout, '0);
    model_reset();
    din_v = 0; flush = 0; replay_go = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    fill_block(200);
    step(1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    expect_seq("replay_after_rst", 32, 200, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      logic [WW-1:0] d;
      for (int k = 0; k < int'(WW / 32); k++) d[k*32 +: 32] = $urandom;
      step(1'($urandom_range(0, 9) < 6), d, 1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 4) == 0), PW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_data_loader.md
# pe_data_loader

Parametrised operand loader that sits in front of a PE's data memory. It captures a block of DEPTH multi-lane words from the input stream and forwards each word downstream as it arrives. Once full, it replays the stored block on command for a programmable number of passes, contiguously and without bubbles. It is the generalised successor of the PE's fixed 32-entry input shift/replay register, adding lane count, a ready handshake, multi-pass replay, flush and an optional reverse order.

## Interface
- DATA_WIDTH, 32: width of one real or imaginary half; one lane word is DATA_WIDTH*2 bits (complex).
- LANES, 1: parallel complex words per beat; all lanes share one address.
- DEPTH, 32: words per lane in the block; power of two, minimum 2.
- PASS_WIDTH, 4: width of the replay pass-count field.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_v  in  1  input beat valid.
- din  in  LANES*DATA_WIDTH*2  input beat.
- din_rdy  out  1  loader accepts a beat this cycle.
- flush  in  1  synchronous clear of contents and state.
- replay_go  in  1  start replay; sampled only in FULL.
- replay_passes  in  PASS_WIDTH  number of passes; 0 is treated as 1.
- replay_rev  in  1  reverse replay order (see Configuration).
- dout_v  out  1  output word valid.
- dout  out  LANES*DATA_WIDTH*2  output word (registered).
- dout_last  out  1  final word of the final replay pass.
- busy  out  1  high in REPLAY.
- fill_lvl  out  clog2(DEPTH+1)  number of words stored.

## Operation
- States: IDLE, FILL, FULL, REPLAY. Reset state is IDLE. All outputs reset to 0, and wptr, raddr and the pass counter reset to 0. Memory contents are not reset.
- din_rdy = 1 in IDLE and FILL; 0 in FULL and REPLAY.
- Accepted beat (din_v & din_rdy):
  - mem[wptr] <= din.
  - dout <= din and dout_v <= 1 (pass-through).
  - wptr and fill_lvl increment.
  - IDLE -> FILL on the first accepted beat.
  - FILL -> FULL on the accept that makes fill_lvl = DEPTH.
  - A DEPTH=2 block goes IDLE -> FILL -> FULL in two beats.
- din_v while din_rdy = 0: the beat is dropped with no side effects.
- FULL + replay_go:
  - Latch passes = max(replay_passes, 1) and the direction.
  - Go to REPLAY. raddr starts at 0 (forward) or DEPTH-1 (reverse).
- REPLAY, every cycle:
  - dout <= mem[raddr], dout_v <= 1.
  - raddr steps by ±1, wrapping modulo DEPTH at the end of each pass.
  - The pass counter decrements at each wrap.
  - dout_last is set with the final word of the final pass.
  - The state returns to FULL on the cycle that word appears on dout. Contents are retained, so a new replay_go may follow immediately.
- Every cycle with no pass-through and no replay: dout_v <= 0 and dout holds its value.
- replay_go outside FULL is ignored.
- flush, in any state:
  - Next state IDLE; wptr = fill_lvl = 0; dout_v and dout_last go to 0 on the next cycle.
  - An in-progress replay is aborted.
  - flush takes priority over a simultaneous din_v or replay_go.
- Asynchronous rst mid-fill or mid-replay: immediate return to the reset values; the replay is not resumed.

## Timing
- Pass-through latency: 1 cycle, din to dout.
- Replay:
  - First word appears 1 cycle after replay_go is sampled.
  - dout_v is high for exactly passes*DEPTH consecutive cycles.
  - dout_last is high for exactly 1 cycle.
- din_rdy falls in the cycle after the DEPTH-th accept and rises in the cycle after flush.
- A back-to-back replay_go asserted in the cycle the state returns to FULL produces no gap in dout_v.
- Throughput: one beat per cycle when filling, one word per cycle when replaying.

## Configuration
- PE_LOADER_REVERSE_EN defined:
  - replay_rev is honoured.
  - Reverse replay reads DEPTH-1 down to 0 on every pass.
- PE_LOADER_REVERSE_EN undefined:
  - replay_rev is ignored; replay is always forward.
  - The down-count and its mux are not built.

## Test plan
- Fill: DEPTH=32, LANES=1, din = 1..32 on consecutive cycles -> dout echoes 1..32, each 1 cycle later; fill_lvl = 32; din_rdy = 0 from the cycle after the 32nd accept; a 33rd beat of 99 is dropped.
- Multi-pass: FULL, replay_go with replay_passes = 2, replay_rev = 0 -> 64 contiguous words 1..32,1..32; dout_last only on the 64th; busy falls afterwards; a second replay_go with replay_passes = 0 -> exactly 32 words.
- Reverse: with PE_LOADER_REVERSE_EN and replay_rev = 1 -> 32..1. Without the macro, the same stimulus -> 1..32.
- Flush: flush on the 10th replay cycle -> dout_v = 0 next cycle, no dout_last, fill_lvl = 0, din_rdy = 1; a new 32-word fill replays the new data.
- Reset: rst asserted after 5 accepted beats -> all outputs 0 immediately; a subsequent 32-word fill and replay behave as from power-up.
- Multi-lane: LANES = 4, lane k = 100k + n -> replay preserves the lane alignment word-for-word.
